// File: rtl/if_stage.sv
// if_stage: instruction fetch with PC, IF/ID register, stall, redirect flush and HALT detection
module if_stage #(
    parameter int ADDR_W = 8,
    parameter int INST_W = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = 8'h00,
    parameter logic [4:0] HALT_OP = 5'b11111
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [INST_W-1:0] imem_data,
    input  logic              stall,
    input  logic              redirect_en,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic [INST_W-1:0] ifid_inst,
    output logic [ADDR_W-1:0] ifid_pc,
    output logic [ADDR_W-1:0] ifid_pc_plus1,
    output logic              ifid_valid,
    output logic              halted,
    output logic [15:0]       fetch_cnt
);
    localparam logic [0:0] RUN = 1'b0;
    localparam logic [0:0] HALTED = 1'b1;
    logic [0:0]        state;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_next;
    logic              is_halt;
    assign imem_addr = pc;
    assign halted = state == HALTED;
    assign pc_next = pc + 1'b1;
    assign is_halt = imem_data[INST_W-1:INST_W-5] == HALT_OP;
    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= RESET_PC;
            ifid_inst <= '0;
            ifid_pc <= '0;
            ifid_pc_plus1 <= '0;
            ifid_valid <= 1'b0;
            state <= RUN;
            fetch_cnt <= '0;
        end else if (redirect_en) begin
            pc <= redirect_pc;
            ifid_valid <= 1'b0;
            state <= RUN;
        end else if (!stall) begin
            if (state == RUN) begin
                ifid_inst <= imem_data;
                ifid_pc <= pc;
                ifid_pc_plus1 <= pc_next;
                ifid_valid <= 1'b1;
                fetch_cnt <= fetch_cnt + 16'd1;
                // the HALT itself is delivered; PC parks on it
                if (is_halt) state <= HALTED;
                else pc <= pc_next;
            end else begin
                ifid_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: directed and randomized checks of if_stage against a fetch-rule reference model
module tb_if_stage;
    logic        clk = 0;
    logic        rst = 0, stall = 0, redirect_en = 0;
    logic [7:0]  redirect_pc = 0;
    logic [7:0]  imem_addr, ifid_pc, ifid_pc_plus1;
    logic [15:0] imem_data, ifid_inst, fetch_cnt;
    logic        ifid_valid, halted;
    logic        rst2 = 0, zero = 0;
    logic [7:0]  zero8 = 0;
    logic [7:0]  imem_addr2, ifid_pc2, ifid_pc_plus12;
    logic [15:0] imem_data2, ifid_inst2, fetch_cnt2;
    logic        ifid_valid2, halted2;
    logic [15:0] rom [256];
    int          errors = 0, checks = 0;
    logic [7:0]  m_pc, m_ipc;
    logic [15:0] m_inst, m_cnt;
    logic        m_valid, m_halt;

    always #5 clk = ~clk;
    assign imem_data = rom[imem_addr];
    assign imem_data2 = rom[imem_addr2];

    if_stage dut (.clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_data(imem_data),
        .stall(stall), .redirect_en(redirect_en), .redirect_pc(redirect_pc),
        .ifid_inst(ifid_inst), .ifid_pc(ifid_pc), .ifid_pc_plus1(ifid_pc_plus1),
        .ifid_valid(ifid_valid), .halted(halted), .fetch_cnt(fetch_cnt));

    if_stage #(.RESET_PC(8'hFE)) dut2 (.clk(clk), .rst(rst2), .imem_addr(imem_addr2),
        .imem_data(imem_data2), .stall(zero), .redirect_en(zero), .redirect_pc(zero8),
        .ifid_inst(ifid_inst2), .ifid_pc(ifid_pc2), .ifid_pc_plus1(ifid_pc_plus12),
        .ifid_valid(ifid_valid2), .halted(halted2), .fetch_cnt(fetch_cnt2));

    // Advance one clock; the model applies the fetch rules using pre-edge values.
    task automatic tick();
        logic [15:0] w;
        @(posedge clk);
        if (rst) begin
            m_pc = 8'h00; m_valid = 0; m_inst = 0; m_ipc = 0; m_cnt = 0; m_halt = 0;
        end else if (redirect_en) begin
            m_pc = redirect_pc; m_valid = 0; m_halt = 0;
        end else if (!stall) begin
            if (!m_halt) begin
                w = rom[m_pc];
                m_inst = w; m_ipc = m_pc; m_valid = 1; m_cnt = m_cnt + 1;
                if (w[15:11] == 5'b11111) m_halt = 1;
                else m_pc = m_pc + 1;
            end else m_valid = 0;
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1; tick(); rst = 0;
        checks++; if (imem_addr !== 8'h00) begin errors++; $display("FAIL reset_addr got=%h exp=00", imem_addr); end
        checks++; if (ifid_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", ifid_valid); end
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted got=%b exp=0", halted); end
        checks++; if (fetch_cnt !== 16'h0) begin errors++; $display("FAIL reset_cnt got=%h exp=0000", fetch_cnt); end
        checks++; if ({ifid_inst, ifid_pc, ifid_pc_plus1} !== 32'h0) begin errors++; $display("FAIL reset_ifid got=%h/%h/%h exp=0", ifid_inst, ifid_pc, ifid_pc_plus1); end
        tick(); tick(); tick();
        checks++; if (ifid_pc !== 8'h02) begin errors++; $display("FAIL fetch_pc got=%h exp=02", ifid_pc); end
        checks++; if (ifid_inst !== 16'h1002) begin errors++; $display("FAIL fetch_inst got=%h exp=1002", ifid_inst); end
        checks++; if (ifid_valid !== 1'b1) begin errors++; $display("FAIL fetch_valid got=%b exp=1", ifid_valid); end
        checks++; if (fetch_cnt !== 16'd3) begin errors++; $display("FAIL fetch_cnt got=%0d exp=3", fetch_cnt); end
        checks++; if (ifid_pc_plus1 !== 8'h03) begin errors++; $display("FAIL fetch_plus1 got=%h exp=03", ifid_pc_plus1); end
    endtask

    task automatic test_stall();
        tick(); tick();
        stall = 1;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++; if (ifid_pc !== 8'h04 || imem_addr !== 8'h05) begin errors++; $display("FAIL stall_hold got=%h/%h exp=04/05", ifid_pc, imem_addr); end
            checks++; if (fetch_cnt !== 16'd5) begin errors++; $display("FAIL stall_cnt got=%0d exp=5", fetch_cnt); end
        end
        stall = 0; tick();
        checks++; if (ifid_pc !== 8'h05 || ifid_inst !== 16'h1005 || fetch_cnt !== 16'd6) begin errors++; $display("FAIL stall_resume got=%h/%h/%0d exp=05/1005/6", ifid_pc, ifid_inst, fetch_cnt); end
    endtask

    task automatic test_redirect();
        stall = 1; redirect_en = 1; redirect_pc = 8'h40; tick();
        stall = 0; redirect_en = 0;
        checks++; if (ifid_valid !== 1'b0 || imem_addr !== 8'h40) begin errors++; $display("FAIL redir_flush got=%b/%h exp=0/40", ifid_valid, imem_addr); end
        checks++; if (fetch_cnt !== 16'd6) begin errors++; $display("FAIL redir_cnt got=%0d exp=6", fetch_cnt); end
        tick();
        checks++; if (ifid_pc !== 8'h40 || ifid_valid !== 1'b1 || ifid_inst !== 16'h1040) begin errors++; $display("FAIL redir_target got=%h/%b/%h exp=40/1/1040", ifid_pc, ifid_valid, ifid_inst); end
    endtask

    task automatic test_halt();
        rom[3] = 16'hF800;
        rst = 1; tick(); rst = 0;
        tick(); tick(); tick();
        stall = 1; tick(); stall = 0;
        checks++; if (halted !== 1'b0 || ifid_pc !== 8'h02 || imem_addr !== 8'h03) begin errors++; $display("FAIL halt_stalled got=%b/%h/%h exp=0/02/03", halted, ifid_pc, imem_addr); end
        tick();
        checks++; if (ifid_inst !== 16'hF800 || ifid_valid !== 1'b1 || halted !== 1'b1 || imem_addr !== 8'h03) begin errors++; $display("FAIL halt_enter got=%h/%b/%b/%h exp=F800/1/1/03", ifid_inst, ifid_valid, halted, imem_addr); end
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++; if (ifid_valid !== 1'b0 || halted !== 1'b1 || imem_addr !== 8'h03 || fetch_cnt !== 16'd4) begin errors++; $display("FAIL halt_idle got=%b/%b/%h/%0d exp=0/1/03/4", ifid_valid, halted, imem_addr, fetch_cnt); end
        end
        redirect_en = 1; redirect_pc = 8'h10; tick(); redirect_en = 0;
        checks++; if (halted !== 1'b0 || ifid_valid !== 1'b0 || imem_addr !== 8'h10) begin errors++; $display("FAIL halt_redir got=%b/%b/%h exp=0/0/10", halted, ifid_valid, imem_addr); end
        tick();
        checks++; if (ifid_pc !== 8'h10 || ifid_valid !== 1'b1 || ifid_inst !== 16'h1010) begin errors++; $display("FAIL halt_resume got=%h/%b/%h exp=10/1/1010", ifid_pc, ifid_valid, ifid_inst); end
        redirect_en = 1; redirect_pc = 8'h03; tick(); redirect_en = 0; tick();
        checks++; if (halted !== 1'b1) begin errors++; $display("FAIL halt_again got=%b exp=1", halted); end
        rst = 1; stall = 1; tick(); rst = 0; stall = 0;
        checks++; if (imem_addr !== 8'h00 || ifid_valid !== 1'b0 || halted !== 1'b0 || fetch_cnt !== 16'd0) begin errors++; $display("FAIL halt_reset got=%h/%b/%b/%0d exp=00/0/0/0", imem_addr, ifid_valid, halted, fetch_cnt); end
        rom[3] = 16'h1003;
    endtask

    task automatic test_wrap();
        logic [7:0] exp_pc [3];
        exp_pc[0] = 8'hFE; exp_pc[1] = 8'hFF; exp_pc[2] = 8'h00;
        rst2 = 1; tick(); rst2 = 0;
        checks++; if (imem_addr2 !== 8'hFE) begin errors++; $display("FAIL wrap_reset got=%h exp=FE", imem_addr2); end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (ifid_pc2 !== exp_pc[i] || ifid_pc_plus12 !== 8'(exp_pc[i] + 8'd1) || ifid_valid2 !== 1'b1) begin errors++; $display("FAIL wrap_seq%0d got=%h/%h/%b exp=%h/%h/1", i, ifid_pc2, ifid_pc_plus12, ifid_valid2, exp_pc[i], 8'(exp_pc[i] + 8'd1)); end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 256; i++) rom[i] = ($urandom_range(0, 11) == 0) ? {5'b11111, 11'(i)} : 16'(i * 16'h0101 + 16'h0300);
        rst = 1; tick(); rst = 0;
        for (int n = 0; n < 400; n++) begin
            rst = ($urandom_range(0, 59) == 0);
            stall = ($urandom_range(0, 3) == 0);
            redirect_en = ($urandom_range(0, 9) == 0);
            redirect_pc = 8'($urandom);
            tick();
            checks++; if (imem_addr !== m_pc || ifid_valid !== m_valid || halted !== m_halt || fetch_cnt !== m_cnt) begin errors++; $display("FAIL rand_state n=%0d got=%h/%b/%b/%0d exp=%h/%b/%b/%0d", n, imem_addr, ifid_valid, halted, fetch_cnt, m_pc, m_valid, m_halt, m_cnt); end
            if (m_valid) begin
                checks++; if (ifid_inst !== m_inst || ifid_pc !== m_ipc || ifid_pc_plus1 !== 8'(m_ipc + 8'd1)) begin errors++; $display("FAIL rand_ifid n=%0d got=%h/%h/%h exp=%h/%h/%h", n, ifid_inst, ifid_pc, ifid_pc_plus1, m_inst, m_ipc, 8'(m_ipc + 8'd1)); end
            end
        end
        rst = 0; stall = 0; redirect_en = 0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = 16'h1000 + 16'(i);
        #2;
        test_reset();
        test_stall();
        test_redirect();
        test_halt();
        test_wrap();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
